un_striping_n: RTL and testbench



---
 rtl/un_striping_n.sv | 104 ++++++++++
 tb/tb_un_striping_n.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/un_striping_n.sv
// Round-robin merge of LANES striped lanes into one word stream.
// Each lane is buffered in its own small FIFO so lanes may arrive skewed or bursty.

module un_striping_n_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk_2f,
    input  logic             reset,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             wr;

    // A full FIFO still accepts a word when its head leaves on the same edge.
    assign wr    = wr_valid && ((count < CAP) || pop);
    assign empty = (count == '0);
    assign head  = mem[rptr];

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr) begin
                mem[wptr] <= wr_data;
                wptr      <= wptr + 1'b1;
            end
            if (pop)
                rptr <= rptr + 1'b1;
            case ({wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_valid && !wr)
                overflow <= 1'b1;
        end
    end
endmodule

module un_striping_n #(
    parameter int WIDTH = 32,
    parameter int LANES = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk_2f,
    input  logic                     reset,
    input  logic [LANES*WIDTH-1:0]   lane_data,
    input  logic [LANES-1:0]         lane_valid,
    output logic [WIDTH-1:0]         data_out,
    output logic                     valid_out,
    output logic [$clog2(LANES)-1:0] lane_ptr,
    output logic [LANES-1:0]         overflow
);
    localparam int PW = $clog2(LANES);

    logic [LANES-1:0][WIDTH-1:0] heads;
    logic [LANES-1:0]            empty;
    logic [LANES-1:0]            pop;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        // Only the lane under the pointer may pop, which keeps output order strict.
        assign pop[i] = (lane_ptr == PW'(i)) && !empty[i];

        un_striping_n_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
            .clk_2f   (clk_2f),
            .reset    (reset),
            .wr_valid (lane_valid[i]),
            .wr_data  (lane_data[i*WIDTH +: WIDTH]),
            .pop      (pop[i]),
            .head     (heads[i]),
            .empty    (empty[i]),
            .overflow (overflow[i])
        );
    end

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            lane_ptr  <= '0;
        end else if (|pop) begin
            data_out  <= heads[lane_ptr];
            valid_out <= 1'b1;
            lane_ptr  <= lane_ptr + 1'b1;
        end else begin
            valid_out <= 1'b0;
        end
    end
endmodule

// File: tb/tb_un_striping_n.sv
// Bench for un_striping_n: directed scenarios plus random traffic against a
// queue-based model of the lane merge.

module tb_un_striping_n;
    localparam int WIDTH = 32;
    localparam int LANES = 4;
    localparam int DEPTH = 4;

    logic                   clk_2f = 1'b0;
    logic                   reset  = 1'b1;
    logic [LANES*WIDTH-1:0] lane_data  = '0;
    logic [LANES-1:0]       lane_valid = '0;
    logic [WIDTH-1:0]       data_out;
    logic                   valid_out;
    logic [1:0]             lane_ptr;
    logic [LANES-1:0]       overflow;

    un_striping_n #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk_2f     (clk_2f),
        .reset      (reset),
        .lane_data  (lane_data),
        .lane_valid (lane_valid),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .lane_ptr   (lane_ptr),
        .overflow   (overflow)
    );

    always #5 clk_2f = ~clk_2f;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: one queue per lane, a round-robin pointer and sticky drop flags.
    logic [WIDTH-1:0] m_q [LANES][$];
    logic [1:0]       m_ptr   = '0;
    logic [LANES-1:0] m_ovf   = '0;
    logic [WIDTH-1:0] m_data  = '0;
    logic             m_valid = 1'b0;

    // Drive one cycle of inputs, clock it, advance the model, settle for sampling.
    task automatic tick(input logic rst, input logic [LANES-1:0] v, input logic [LANES*WIDTH-1:0] d);
        bit popped;
        reset      = rst;
        lane_valid = v;
        lane_data  = d;
        @(posedge clk_2f);
        if (rst) begin
            for (int i = 0; i < LANES; i++) m_q[i].delete();
            m_ptr = '0; m_ovf = '0; m_valid = 1'b0; m_data = '0;
        end else begin
            popped = (m_q[m_ptr].size() > 0);
            if (popped) m_data = m_q[m_ptr].pop_front();
            m_valid = popped;
            for (int i = 0; i < LANES; i++)
                if (v[i]) begin
                    if (m_q[i].size() < DEPTH) m_q[i].push_back(d[i*WIDTH +: WIDTH]);
                    else m_ovf[i] = 1'b1;
                end
            if (popped) m_ptr = m_ptr + 2'd1;
        end
        #1;
    endtask

    function automatic logic [LANES*WIDTH-1:0] rnd_data();
        logic [LANES*WIDTH-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*WIDTH +: WIDTH] = $urandom;
        return r;
    endfunction

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            tick(1'b1, LANES'($urandom), rnd_data());
            n_tests++;
            if ({valid_out, data_out, lane_ptr, overflow} !== '0) begin
                n_fail++;
                $display("FAIL reset cyc%0d: got v=%b d=%h p=%0d o=%b, want all zero",
                         c, valid_out, data_out, lane_ptr, overflow);
            end
        end
        for (int c = 0; c < 3; c++) begin
            tick(1'b0, '0, rnd_data());
            n_tests++;
            if (valid_out !== 1'b0 || lane_ptr !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_idle cyc%0d: got v=%b p=%0d, want v=0 p=0", c, valid_out, lane_ptr);
            end
        end
    endtask

    task automatic test_in_order();
        logic [WIDTH-1:0] outs[$];
        logic [WIDTH-1:0] w;
        int first = -1;
        for (int c = 0; c < 8; c++) begin
            w = WIDTH'(32'h1111_1111 * (c + 1));
            if (c < 4) tick(1'b0, LANES'(1 << c), (LANES*WIDTH)'(w) << (c*WIDTH));
            else       tick(1'b0, '0, '0);
            n_tests++;
            if ({valid_out, data_out, lane_ptr, overflow} !== {m_valid, m_data, m_ptr, m_ovf}) begin
                n_fail++;
                $display("FAIL in_order cyc%0d: got v=%b d=%h p=%0d o=%b want v=%b d=%h p=%0d o=%b",
                         c, valid_out, data_out, lane_ptr, overflow, m_valid, m_data, m_ptr, m_ovf);
            end
            if (valid_out) begin
                if (first < 0) first = c;
                outs.push_back(data_out);
            end
        end
        n_tests++;
        if (first != 1 || outs.size() != 4 || outs[0] !== 32'h1111_1111 || outs[1] !== 32'h2222_2222 ||
            outs[2] !== 32'h3333_3333 || outs[3] !== 32'h4444_4444 || lane_ptr !== 2'd0) begin
            n_fail++;
            $display("FAIL in_order_seq: got first=%0d n=%0d p=%0d, want first=1 n=4 11..44 p=0",
                     first, outs.size(), lane_ptr);
        end
    endtask

    task automatic test_skew();
        logic [WIDTH-1:0] outs[$];
        for (int c = 0; c < 7; c++) begin
            case (c)
                0:       tick(1'b0, 4'b0010, (LANES*WIDTH)'(32'hB0) << WIDTH);
                3:       tick(1'b0, 4'b0001, (LANES*WIDTH)'(32'hA0));
                default: tick(1'b0, '0, '0);
            endcase
            n_tests++;
            if ({valid_out, data_out, lane_ptr, overflow} !== {m_valid, m_data, m_ptr, m_ovf}) begin
                n_fail++;
                $display("FAIL skew cyc%0d: got v=%b d=%h p=%0d want v=%b d=%h p=%0d",
                         c, valid_out, data_out, lane_ptr, m_valid, m_data, m_ptr);
            end
            if (c <= 3) begin
                n_tests++;
                if (valid_out !== 1'b0 || lane_ptr !== 2'd0) begin
                    n_fail++;
                    $display("FAIL skew_wait cyc%0d: got v=%b p=%0d want v=0 p=0", c, valid_out, lane_ptr);
                end
            end
            if (valid_out) outs.push_back(data_out);
        end
        n_tests++;
        if (outs.size() != 2 || outs[0] !== 32'hA0 || outs[1] !== 32'hB0 || lane_ptr !== 2'd2) begin
            n_fail++;
            $display("FAIL skew_seq: got n=%0d p=%0d, want A0,B0 p=2", outs.size(), lane_ptr);
        end
    endtask

    task automatic test_burst();
        logic [WIDTH-1:0] outs[$];
        // Pointer sits at 2; drain so the burst starts at lane 0 via lanes 2,3 words.
        tick(1'b0, 4'b1100, {32'hD3, 32'hD2, 64'h0});
        for (int c = 0; c < 3; c++) tick(1'b0, '0, '0);
        for (int c = 0; c < 7; c++) begin
            if (c == 0) tick(1'b0, 4'b1111, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
            else        tick(1'b0, '0, '0);
            n_tests++;
            if ({valid_out, data_out, lane_ptr, overflow} !== {m_valid, m_data, m_ptr, m_ovf}) begin
                n_fail++;
                $display("FAIL burst cyc%0d: got v=%b d=%h p=%0d want v=%b d=%h p=%0d",
                         c, valid_out, data_out, lane_ptr, m_valid, m_data, m_ptr);
            end
            if (valid_out) outs.push_back(data_out);
        end
        n_tests++;
        if (outs.size() != 4 || outs[0] !== 32'hC0 || outs[1] !== 32'hC1 ||
            outs[2] !== 32'hC2 || outs[3] !== 32'hC3) begin
            n_fail++;
            $display("FAIL burst_seq: got n=%0d, want C0..C3", outs.size());
        end
    endtask

    task automatic test_overflow();
        logic [WIDTH-1:0] outs[$];
        for (int c = 0; c < 6; c++) begin
            tick(1'b0, 4'b0100, (LANES*WIDTH)'(c + 1) << (2*WIDTH));
            n_tests++;
            if (overflow !== ((c >= 4) ? 4'b0100 : 4'b0000)) begin
                n_fail++;
                $display("FAIL ovf_flag word%0d: got o=%b want %b", c + 1, overflow,
                         (c >= 4) ? 4'b0100 : 4'b0000);
            end
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 5; c++) begin
                if (c == 0) tick(1'b0, 4'b1011, {32'hF3 + 32'(r << 8), 32'h0, 32'hF1 + 32'(r << 8), 32'hF0 + 32'(r << 8)});
                else        tick(1'b0, '0, '0);
                n_tests++;
                if ({valid_out, data_out, lane_ptr, overflow} !== {m_valid, m_data, m_ptr, m_ovf}) begin
                    n_fail++;
                    $display("FAIL ovf_drain r%0d c%0d: got v=%b d=%h p=%0d o=%b want v=%b d=%h p=%0d o=%b",
                             r, c, valid_out, data_out, lane_ptr, overflow, m_valid, m_data, m_ptr, m_ovf);
                end
                if (valid_out) outs.push_back(data_out);
            end
        n_tests++;
        if (outs.size() != 16 || outs[2] !== 32'd1 || outs[6] !== 32'd2 || outs[10] !== 32'd3 ||
            outs[14] !== 32'd4 || overflow !== 4'b0100) begin
            n_fail++;
            $display("FAIL ovf_seq: got n=%0d o=%b, want 16 words with lane2=1,2,3,4 o=0100",
                     outs.size(), overflow);
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b0, 4'b1110, {32'hE3, 32'hE2, 32'hE1, 32'h0});
        tick(1'b1, 4'b1111, rnd_data());
        n_tests++;
        if ({valid_out, data_out, lane_ptr, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got v=%b d=%h p=%0d o=%b want all zero",
                     valid_out, data_out, lane_ptr, overflow);
        end
        for (int c = 0; c < 4; c++) begin
            if (c == 1) tick(1'b0, 4'b0001, (LANES*WIDTH)'(32'h5A5A_0001));
            else        tick(1'b0, '0, '0);
            n_tests++;
            if (valid_out !== (c == 2) || (c == 2 && data_out !== 32'h5A5A_0001)) begin
                n_fail++;
                $display("FAIL reset_mid_after cyc%0d: got v=%b d=%h want v=%b d=5a5a0001",
                         c, valid_out, data_out, c == 2);
            end
        end
    endtask

    task automatic test_random();
        logic rst;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 99) < 2);
            tick(rst, LANES'($urandom) & LANES'($urandom), rnd_data());
            n_tests++;
            if ({valid_out, data_out, lane_ptr, overflow} !== {m_valid, m_data, m_ptr, m_ovf}) begin
                n_fail++;
                $display("FAIL random cyc%0d: got v=%b d=%h p=%0d o=%b want v=%b d=%h p=%0d o=%b",
                         c, valid_out, data_out, lane_ptr, overflow, m_valid, m_data, m_ptr, m_ovf);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_in_order();
        test_skew();
        test_burst();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
